// File: rtl/neuron_layer_scheduler_if.sv
// Layer-scheduler bundle: start/status, datapath issue port, and result stream.
interface neuron_layer_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic             busy;
  logic             issue_valid;
  logic [IDX_W-1:0] issue_idx;
  logic [31:0]      dp_result;
  logic             res_valid;
  logic [IDX_W-1:0] res_idx;
  logic [31:0]      res_data;
  logic             done;
  logic             start_err;

  modport slave (
    input  start, dp_result,
    output busy, issue_valid, issue_idx, res_valid, res_idx, res_data, done, start_err
  );

  modport master (
    output start, dp_result,
    input  busy, issue_valid, issue_idx, res_valid, res_idx, res_data, done, start_err
  );
endinterface

// File: rtl/neuron_layer_scheduler.sv
// Time-multiplexes NUM_NEURONS neurons onto one fixed-latency datapath and
// re-associates each datapath output with its neuron index via a tag pipeline.
module neuron_layer_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int LATENCY     = 6,
  parameter int IDX_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  neuron_layer_scheduler_if.slave   lyr
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             issue_valid_q;
  logic             busy_q;
  logic             start_err_q;
  logic             res_valid_q;
  logic             done_q;
  logic [IDX_W-1:0] res_idx_q;
  logic [31:0]      res_data_q;

  logic [LATENCY-1:0] tag_vld_q;
  logic [IDX_W-1:0]   tag_idx_q [LATENCY];

  logic tag_hit;
  logic tag_last;

  assign tag_hit  = tag_vld_q[LATENCY-1];
  assign tag_last = tag_hit && (tag_idx_q[LATENCY-1] == LAST_IDX);

  // Tag indices only matter when their valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_idx_q[0] <= cnt_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_idx_q[i] <= tag_idx_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      start_err_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      res_idx_q     <= '0;
      res_data_q    <= '0;
      tag_vld_q     <= '0;
    end else begin
      tag_vld_q[0] <= issue_valid_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
      end

      res_valid_q <= tag_hit;
      done_q      <= tag_last;
      if (tag_hit) begin
        res_idx_q  <= tag_idx_q[LATENCY-1];
        res_data_q <= lyr.dp_result;
      end

      start_err_q <= lyr.start && (state_q != IDLE);

      case (state_q)
        IDLE: begin
          if (lyr.start) begin
            state_q       <= ISSUE;
            cnt_q         <= '0;
            issue_valid_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ISSUE: begin
          if (cnt_q == LAST_IDX) begin
            state_q       <= DRAIN;
            issue_valid_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          // Leaving on the final result's tag lets a start in the done cycle be taken.
          if (tag_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          issue_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign lyr.busy        = busy_q;
  assign lyr.issue_valid = issue_valid_q;
  assign lyr.issue_idx   = cnt_q;
  assign lyr.res_valid   = res_valid_q;
  assign lyr.res_idx     = res_idx_q;
  assign lyr.res_data    = res_data_q;
  assign lyr.done        = done_q;
  assign lyr.start_err   = start_err_q;

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Directed bench: default layer (10 neurons, latency 6) plus a 1-neuron, latency-1 instance.
module tb_neuron_layer_scheduler;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  neuron_layer_scheduler_if #(.IDX_W(4)) if0 ();
  neuron_layer_scheduler_if #(.IDX_W(4)) if1 ();

  neuron_layer_scheduler #(.NUM_NEURONS(10), .LATENCY(6), .IDX_W(4)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .lyr (if0)
  );

  neuron_layer_scheduler #(.NUM_NEURONS(1), .LATENCY(1), .IDX_W(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .lyr (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-ins: fixed-latency pipes whose output encodes the issued index.
  logic [3:0] dp0_q [6];
  logic [3:0] dp1_q;

  always @(posedge clk) begin
    dp0_q[0] <= if0.issue_idx;
    for (int i = 1; i < 6; i++) dp0_q[i] <= dp0_q[i-1];
    dp1_q <= if1.issue_idx;
  end

  assign if0.dp_result = 32'h3F00_0000 + {28'h0, dp0_q[5]};
  assign if1.dp_result = 32'h3F00_0000 + {28'h0, dp1_q};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic chk_zero0(input string pfx);
    chk({pfx, "_busy"},        {31'h0, if0.busy},        32'h0);
    chk({pfx, "_issue_valid"}, {31'h0, if0.issue_valid}, 32'h0);
    chk({pfx, "_issue_idx"},   {28'h0, if0.issue_idx},   32'h0);
    chk({pfx, "_res_valid"},   {31'h0, if0.res_valid},   32'h0);
    chk({pfx, "_res_idx"},     {28'h0, if0.res_idx},     32'h0);
    chk({pfx, "_res_data"},    if0.res_data,             32'h0);
    chk({pfx, "_done"},        {31'h0, if0.done},        32'h0);
    chk({pfx, "_start_err"},   {31'h0, if0.start_err},   32'h0);
  endtask

  // Expected outputs of the default instance in cycle c after a start in cycle 0;
  // b2b selects start held high so a second layer starts in cycle 17.
  task automatic chk_cycle(input string pfx, input int c, input bit b2b);
    logic        iv, rv, bsy, dn, serr;
    logic [31:0] idx;
    string       t;
    iv   = (c >= 1 && c <= 10) || (b2b && c >= 18);
    idx  = (c >= 1 && c <= 10) ? 32'(c - 1) : ((b2b && c >= 18) ? 32'(c - 18) : 32'd9);
    rv   = (c >= 8 && c <= 17);
    bsy  = (c >= 1 && c <= 16) || (b2b && c >= 18);
    dn   = (c == 17);
    serr = b2b && ((c >= 2 && c <= 17) || c >= 19);
    t = $sformatf("%s_c%0d", pfx, c);
    chk({t, "_issue_valid"}, {31'h0, if0.issue_valid}, {31'h0, iv});
    chk({t, "_issue_idx"},   {28'h0, if0.issue_idx},   idx);
    chk({t, "_res_valid"},   {31'h0, if0.res_valid},   {31'h0, rv});
    chk({t, "_busy"},        {31'h0, if0.busy},        {31'h0, bsy});
    chk({t, "_done"},        {31'h0, if0.done},        {31'h0, dn});
    chk({t, "_start_err"},   {31'h0, if0.start_err},   {31'h0, serr});
    if (rv) begin
      chk({t, "_res_idx"},  {28'h0, if0.res_idx}, 32'(c - 8));
      chk({t, "_res_data"}, if0.res_data,         32'h3F00_0000 + 32'(c - 8));
    end
    if (c == 18) begin
      chk({t, "_res_idx_hold"},  {28'h0, if0.res_idx}, 32'd9);
      chk({t, "_res_data_hold"}, if0.res_data,         32'h3F00_0009);
    end
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rst         = 1'b1;
    if0.start   = 1'b0;
    if1.start   = 1'b0;

    repeat (2) step();
    chk_zero0("reset");
    chk("reset_dut1_busy",        {31'h0, if1.busy},        32'h0);
    chk("reset_dut1_issue_valid", {31'h0, if1.issue_valid}, 32'h0);

    // Release reset; the start in the very next cycle must be taken.
    rst = 1'b0;
    step();
    if0.start = 1'b1;
    chk("l1_c0_busy", {31'h0, if0.busy}, 32'h0);
    step();
    if0.start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      chk_cycle("l1", c, 1'b0);
      if (c < 18) step();
    end

    // Start held high: back-to-back layers and start_err for starts while busy.
    if0.start = 1'b1;
    step();
    for (int c = 1; c <= 19; c++) begin
      chk_cycle("b2b", c, 1'b1);
      if (c < 19) step();
    end
    if0.start = 1'b0;

    // The third layer began in b2b cycle 18; move to its cycle 9 and reset asynchronously.
    repeat (7) step();
    chk("l3_c9_res_valid_pre", {31'h0, if0.res_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk_zero0("async_rst");
    step();
    rst = 1'b0;
    chk_zero0("rst_release");
    step();
    chk("post_rst1_res_valid", {31'h0, if0.res_valid}, 32'h0);
    chk("post_rst1_done",      {31'h0, if0.done},      32'h0);
    step();
    if0.start = 1'b1;
    chk("post_rst2_res_valid", {31'h0, if0.res_valid}, 32'h0);
    chk("post_rst2_busy",      {31'h0, if0.busy},      32'h0);
    step();
    if0.start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      chk_cycle("l4", c, 1'b0);
      if (c < 18) step();
    end

    // Single neuron, latency 1: issue in cycle 1, result and done in cycle 3.
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      string t;
      t = $sformatf("n1_c%0d", c);
      chk({t, "_issue_valid"}, {31'h0, if1.issue_valid}, {31'h0, c == 1});
      chk({t, "_issue_idx"},   {28'h0, if1.issue_idx},   32'h0);
      chk({t, "_res_valid"},   {31'h0, if1.res_valid},   {31'h0, c == 3});
      chk({t, "_done"},        {31'h0, if1.done},        {31'h0, c == 3});
      chk({t, "_busy"},        {31'h0, if1.busy},        {31'h0, c <= 2});
      chk({t, "_res_idx"},     {28'h0, if1.res_idx},     32'h0);
      chk({t, "_res_data"},    if1.res_data,             (c >= 3) ? 32'h3F00_0000 : 32'h0);
      if (c < 4) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
